// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_pkg
//  Description : Shared motion-estimation types and width helpers. Used by
//                the PE array, the SAD minimum search and mode decision.
//                  sms_state_t : IDLE / RUN / DONE for the SAD minimum search
//                  sadw()      : width of one full-block SAD
//                  mvw()       : width of one signed motion-vector component
//  Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sms_state_t;

    // Wide enough for NPE*BLK*(2^PIXWIDTH-1), so block sums never overflow.
    function automatic int sadw(input int pixwidth, input int npe, input int blk);
        return pixwidth + $clog2(npe) + $clog2(blk);
    endfunction

    // mv spans -range..range-1 in two's complement.
    function automatic int mvw(input int range);
        return $clog2(2 * range);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sad_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : sad_adder_tree
//  Description : Combinational NPE-input adder tree. Sums the per-PE sad
//                values of one row beat.
//  Ports       : sad_in  - packed PE values, PE k at [k*PIXWIDTH +: PIXWIDTH]
//                row_sum - unsigned sum, PIXWIDTH+$clog2(NPE) bits
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_adder_tree #(
    parameter int PIXWIDTH = 8,
    parameter int NPE      = 16,
    parameter int OUTW     = PIXWIDTH + $clog2(NPE)
) (
    input  logic [NPE*PIXWIDTH-1:0] sad_in,
    output logic [OUTW-1:0]         row_sum
);

    // Leaves are padded up to a power of two so the tree is a complete
    // binary heap: node i has children 2i+1 and 2i+2, root is node 0.
    localparam int c_NP2 = 1 << $clog2(NPE);

    logic [c_NP2*PIXWIDTH-1:0] w_padded;
    logic [OUTW-1:0]           w_node [0:2*c_NP2-2];

    always_comb begin
        w_padded                   = '0;
        w_padded[NPE*PIXWIDTH-1:0] = sad_in;
        for (int k = 0; k < c_NP2; k++) begin
            w_node[c_NP2-1+k] = OUTW'(w_padded[k*PIXWIDTH +: PIXWIDTH]);
        end
        // Walk from the deepest internal node up so children are ready.
        for (int i = c_NP2 - 2; i >= 0; i--) begin
            w_node[i] = w_node[2*i+1] + w_node[2*i+2];
        end
        row_sum = w_node[0];
    end

endmodule
`default_nettype wire

// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================================
//  Module      : sad_min_search
//  Description : Sums each row beat of PE sad values, accumulates BLK beats
//                into one candidate SAD, and tracks the minimum candidate
//                and its motion vector over the (2*RANGE)^2 search window.
//  Ports       : clk, rst (async, active high)
//                start     - 1-cycle pulse, sampled only in IDLE
//                sad_valid - sad_in carries a row beat this cycle
//                sad_in    - packed PE sad values
//                busy      - high from the cycle after start until done
//                done      - 1-cycle pulse, results final this cycle
//                min_sad   - best candidate SAD
//                mv_x/mv_y - signed motion vector of the best candidate
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_min_search
    import me_pkg::*;
#(
    parameter int PIXWIDTH = 8,
    parameter int NPE      = 16,
    parameter int BLK      = 16,
    parameter int RANGE    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  sad_valid,
    input  logic [NPE*PIXWIDTH-1:0]               sad_in,
    output logic                                  busy,
    output logic                                  done,
    output logic [sadw(PIXWIDTH, NPE, BLK)-1:0]   min_sad,
    output logic signed [mvw(RANGE)-1:0]          mv_x,
    output logic signed [mvw(RANGE)-1:0]          mv_y
);

    localparam int c_SADW = sadw(PIXWIDTH, NPE, BLK);
    localparam int c_MVW  = mvw(RANGE);
    localparam int c_ROWW = PIXWIDTH + $clog2(NPE);
    localparam int c_CNTW = (BLK > 1) ? $clog2(BLK) : 1;

    localparam logic [c_CNTW-1:0] c_ROW_LAST = c_CNTW'(BLK - 1);
    localparam logic [c_MVW-1:0]  c_POS_LAST = c_MVW'(2 * RANGE - 1);
    localparam logic [c_MVW-1:0]  c_OFFSET   = c_MVW'(RANGE);

    sms_state_t         r_state;
    logic [c_ROWW-1:0]  w_row_sum;
    logic [c_ROWW-1:0]  r_row_sum;
    logic               r_vld1;
    logic [c_SADW-1:0]  r_acc;
    logic [c_CNTW-1:0]  r_row_cnt;
    logic [c_MVW-1:0]   r_cx;
    logic [c_MVW-1:0]   r_cy;
    logic [c_SADW-1:0]  w_cand;
    logic               w_accept;

    sad_adder_tree #(
        .PIXWIDTH (PIXWIDTH),
        .NPE      (NPE),
        .OUTW     (c_ROWW)
    ) u_tree (
        .sad_in  (sad_in),
        .row_sum (w_row_sum)
    );

    // Beats are only taken while searching; anything seen in IDLE or DONE
    // (including beats after the final candidate) is dropped here.
    assign w_accept = (r_state == RUN) && sad_valid;
    assign w_cand   = r_acc + c_SADW'(r_row_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            min_sad   <= '1;
            mv_x      <= '0;
            mv_y      <= '0;
            r_row_sum <= '0;
            r_vld1    <= 1'b0;
            r_acc     <= '0;
            r_row_cnt <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else begin
            done   <= 1'b0;

            // Stage 1: register the beat sum.
            r_vld1 <= w_accept;
            if (w_accept) begin
                r_row_sum <= w_row_sum;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        busy      <= 1'b1;
                        min_sad   <= '1;
                        mv_x      <= '0;
                        mv_y      <= '0;
                        r_acc     <= '0;
                        r_row_cnt <= '0;
                        r_cx      <= '0;
                        r_cy      <= '0;
                    end
                end

                RUN: begin
                    // Stage 2: accumulate, and on the last row close out the
                    // candidate and compare. Strict < keeps the earliest tie.
                    if (r_vld1) begin
                        if (r_row_cnt != c_ROW_LAST) begin
                            r_acc     <= w_cand;
                            r_row_cnt <= r_row_cnt + c_CNTW'(1);
                        end else begin
                            r_acc     <= '0;
                            r_row_cnt <= '0;
                            if (w_cand < min_sad) begin
                                min_sad <= w_cand;
                                mv_x    <= r_cx - c_OFFSET;
                                mv_y    <= r_cy - c_OFFSET;
                            end
                            if (r_cx == c_POS_LAST) begin
                                r_cx <= '0;
                                if (r_cy == c_POS_LAST) begin
                                    r_state <= DONE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end else begin
                                    r_cy <= r_cy + c_MVW'(1);
                                end
                            end else begin
                                r_cx <= r_cx + c_MVW'(1);
                            end
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_min_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_min_search
//  Description : Self-checking bench for sad_min_search. A small NPE=4,
//                BLK=4, RANGE=2 instance carries most scenarios; a
//                default-parameter instance covers the full-width case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_min_search;

    localparam int PW    = 8;
    localparam int NPE   = 4;
    localparam int BLK   = 4;
    localparam int RANGE = 2;
    localparam int SADW  = 12;
    localparam int MVW   = 2;
    localparam int NPOS  = 2 * RANGE;
    localparam int NBEAT = NPOS * NPOS * BLK;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  sad_valid;
    logic [NPE*PW-1:0]     sad_in;
    logic                  busy;
    logic                  done;
    logic [SADW-1:0]       min_sad;
    logic signed [MVW-1:0] mv_x;
    logic signed [MVW-1:0] mv_y;

    logic                  start2;
    logic                  sad_valid2;
    logic [16*8-1:0]       sad_in2;
    logic                  busy2;
    logic                  done2;
    logic [15:0]           min_sad2;
    logic signed [3:0]     mv_x2;
    logic signed [3:0]     mv_y2;

    always #5 clk = ~clk;

    sad_min_search #(
        .PIXWIDTH (PW),
        .NPE      (NPE),
        .BLK      (BLK),
        .RANGE    (RANGE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .busy      (busy),
        .done      (done),
        .min_sad   (min_sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y)
    );

    sad_min_search dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .sad_valid (sad_valid2),
        .sad_in    (sad_in2),
        .busy      (busy2),
        .done      (done2),
        .min_sad   (min_sad2),
        .mv_x      (mv_x2),
        .mv_y      (mv_y2)
    );

    typedef struct packed {
        logic [SADW-1:0] sad;
        logic [MVW-1:0]  mx;
        logic [MVW-1:0]  my;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // PE value for every beat of candidate cand under a stimulus mode.
    function automatic logic [7:0] pe_val(input int mode, input int cand);
        case (mode)
            0:       return 8'd0;
            1:       return (cand == 9) ? 8'd0 : 8'd1;
            default: return 8'd255;
        endcase
    endfunction

    // Reference search: strict minimum over the scan order.
    function automatic exp_t model(input int mode);
        exp_t e;
        int   best = (1 << SADW) - 1;
        e.sad = '1; e.mx = '0; e.my = '0;
        for (int c = 0; c < NPOS * NPOS; c++) begin
            int s = BLK * NPE * int'(pe_val(mode, c));
            if (s < best) begin
                best  = s;
                e.sad = SADW'(s);
                e.mx  = MVW'((c % NPOS) - RANGE);
                e.my  = MVW'((c / NPOS) - RANGE);
            end
        end
        return e;
    endfunction

    task automatic pulse_start(input int mode);
        sb.push_back(model(mode));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send_beat(input logic [7:0] v);
        sad_valid = 1'b1;
        sad_in    = {NPE{v}};
        @(posedge clk); #1;
        sad_valid = 1'b0;
        sad_in    = '0;
    endtask

    task automatic send_search(input int mode, input bit gapped, input bit poke, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (poke && (b == 10 || b == 40)) start = 1'b1;
            send_beat(pe_val(mode, b / BLK));
            start = 1'b0;
            if (gapped && b != nbeats - 1) begin
                @(posedge clk); #1;
                if (b == 29) repeat (10) begin @(posedge clk); #1; end
            end
        end
    endtask

    // Called right after the final beat was sampled; done must appear at
    // the very next sample point (2 cycles after the beat was presented).
    task automatic wait_done(input string tag);
        int   n = 0;
        exp_t e;
        chk({tag, "_no_early_done"}, done, 0);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 20);
        chk({tag, "_done_latency"}, n, 1);
        chk({tag, "_busy_low_at_done"}, busy, 0);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_min_sad"}, min_sad, e.sad);
            chk({tag, "_mv_x"}, $unsigned(mv_x), e.mx);
            chk({tag, "_mv_y"}, $unsigned(mv_y), e.my);
        end
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int          n;
        int          cnt_before;
        logic [3:0]  e_mv2;

        rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0;
        start2 = 1'b0; sad_valid2 = 1'b0; sad_in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_min_sad", min_sad, 12'hFFF);
        chk("reset_mv_x", $unsigned(mv_x), 0);
        chk("reset_mv_y", $unsigned(mv_y), 0);
        chk("reset_min_sad2", min_sad2, 16'hFFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: all zero, tie keeps the first candidate
        pulse_start(0);
        send_search(0, 1'b0, 1'b0, NBEAT);
        wait_done("s1");

        // 2: candidate 9 is the only zero-SAD block
        pulse_start(1);
        send_search(1, 1'b0, 1'b0, NBEAT);
        wait_done("s2");

        // 3: saturated pixels, small params
        pulse_start(2);
        send_search(2, 1'b0, 1'b0, NBEAT);
        wait_done("s3");

        // 3b: saturated pixels, default params
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int b = 0; b < 16 * 16 * 16; b++) begin
            sad_valid2 = 1'b1;
            sad_in2    = {16{8'hFF}};
            @(posedge clk); #1;
        end
        sad_valid2 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done2 && n < 20);
        e_mv2 = -4'sd8;
        chk("s3b_done_latency", n, 1);
        chk("s3b_min_sad", min_sad2, 32'd65280);
        chk("s3b_mv_x", $unsigned(mv_x2), e_mv2);
        chk("s3b_mv_y", $unsigned(mv_y2), e_mv2);

        // 4: scenario 2 with sparse valid and a long mid-candidate gap
        pulse_start(1);
        send_search(1, 1'b1, 1'b0, NBEAT);
        wait_done("s4");

        // 5: reset mid-search, then a clean rerun
        pulse_start(1);
        send_search(1, 1'b0, 1'b0, 30);
        void'(sb.pop_back());
        rst = 1'b1;
        #1;
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_min_sad", min_sad, 12'hFFF);
        chk("s5_rst_mv_x", $unsigned(mv_x), 0);
        chk("s5_rst_mv_y", $unsigned(mv_y), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_start(1);
        send_search(1, 1'b0, 1'b0, NBEAT);
        wait_done("s5");

        // 6: beats while idle, then start pokes while busy
        cnt_before = done_cnt;
        for (int b = 0; b < 6; b++) send_beat(8'd7);
        repeat (3) begin @(posedge clk); #1; end
        chk("s6_idle_busy", busy, 0);
        chk("s6_idle_min_sad", min_sad, 0);
        chk("s6_idle_done_cnt", done_cnt, cnt_before);
        pulse_start(0);
        send_search(0, 1'b0, 1'b1, NBEAT);
        wait_done("s6");
        repeat (10) begin @(posedge clk); #1; end
        chk("s6_one_done_per_start", done_cnt, cnt_before + 1);
        chk("s6_back_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
